// File: rtl/btb_predictor.sv
// Branch target buffer with per-entry 2-bit saturating counters.
// Registered fetch lookup, decode-time allocation and execute-time training.
module btb_predictor #(
  parameter int          ADDR_W   = 32,
  parameter int          ENTRIES  = 4,
  parameter logic [1:0]  INIT_CTR = 2'b01
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] f_pc,
  output logic [ADDR_W-1:0] f_predict_addr,
  output logic              f_predict_valid,
  input  logic              d_is_branch,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [ADDR_W-1:0] d_target,
  input  logic              x_valid,
  input  logic [ADDR_W-1:0] x_pc,
  input  logic              x_taken,
  input  logic [ADDR_W-1:0] x_target
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid;
  logic [ADDR_W-1:0]  tag    [ENTRIES];
  logic [ADDR_W-1:0]  target [ENTRIES];
  logic [1:0]         ctr    [ENTRIES];
  logic [IDX_W-1:0]   rr;

  logic             f_hit, d_hit, x_hit, free_any;
  logic [IDX_W-1:0] f_idx, x_idx, free_idx, victim;
  logic             alloc, train, pred;

  // Descending scan so the lowest matching / free index is the one kept.
  always_comb begin
    f_hit    = 1'b0;
    d_hit    = 1'b0;
    x_hit    = 1'b0;
    free_any = 1'b0;
    f_idx    = '0;
    x_idx    = '0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && tag[i] == f_pc) begin
        f_hit = 1'b1;
        f_idx = IDX_W'(i);
      end
      if (valid[i] && tag[i] == x_pc) begin
        x_hit = 1'b1;
        x_idx = IDX_W'(i);
      end
      if (valid[i] && tag[i] == d_pc)
        d_hit = 1'b1;
      if (!valid[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign victim = free_any ? free_idx : rr;
  assign alloc  = d_is_branch && !d_hit;
  // Allocation overwrites the entry, so training aimed at the victim is lost.
  assign train  = x_valid && x_hit && !(alloc && victim == x_idx);
  assign pred   = f_hit && ctr[f_idx][1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid           <= '0;
      rr              <= '0;
      f_predict_valid <= 1'b0;
      f_predict_addr  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= 2'b00;
      end
    end else begin
      f_predict_valid <= pred;
      f_predict_addr  <= pred ? target[f_idx] : '0;

      if (train) begin
        if (x_taken) begin
          if (ctr[x_idx] != 2'b11)
            ctr[x_idx] <= ctr[x_idx] + 2'd1;
          target[x_idx] <= x_target;
        end else if (ctr[x_idx] != 2'b00) begin
          ctr[x_idx] <= ctr[x_idx] - 2'd1;
        end
      end

      if (alloc) begin
        valid[victim]  <= 1'b1;
        tag[victim]    <= d_pc;
        target[victim] <= d_target;
        ctr[victim]    <= INIT_CTR;
        if (!free_any)
          rr <= rr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: hand-derived vector table, reset corner
// case, then randomized traffic checked against a behavioural table model.
module tb_btb_predictor;
  localparam int AW = 32;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] f_pc, d_pc, d_target, x_pc, x_target;
  logic [AW-1:0] f_predict_addr;
  logic          f_predict_valid, d_is_branch, x_valid, x_taken;

  always #5 clk = ~clk;

  btb_predictor #(.ADDR_W(AW), .ENTRIES(N), .INIT_CTR(2'b01)) dut (
    .clk(clk), .reset(reset), .f_pc(f_pc),
    .f_predict_addr(f_predict_addr), .f_predict_valid(f_predict_valid),
    .d_is_branch(d_is_branch), .d_pc(d_pc), .d_target(d_target),
    .x_valid(x_valid), .x_pc(x_pc), .x_taken(x_taken), .x_target(x_target)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rst;
    logic [AW-1:0] f;
    logic          db;
    logic [AW-1:0] dp, dt;
    logic          xv;
    logic [AW-1:0] xp;
    logic          xt;
    logic [AW-1:0] xg;
    logic          ev;
    logic [AW-1:0] ea;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [AW-1:0] f, logic db, logic [AW-1:0] dp,
                              logic [AW-1:0] dt, logic xv, logic [AW-1:0] xp, logic xt,
                              logic [AW-1:0] xg, logic ev, logic [AW-1:0] ea);
    vec_t v;
    v.rst = rst; v.f = f; v.db = db; v.dp = dp; v.dt = dt;
    v.xv = xv; v.xp = xp; v.xt = xt; v.xg = xg; v.ev = ev; v.ea = ea;
    return v;
  endfunction

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; f_pc = v.f;
    d_is_branch = v.db; d_pc = v.dp; d_target = v.dt;
    x_valid = v.xv; x_pc = v.xp; x_taken = v.xt; x_target = v.xg;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: the table as plain arrays, updated by the stated rules.
  bit          m_v   [N];
  int unsigned m_tag [N];
  int unsigned m_tgt [N];
  int          m_ctr [N];
  int          m_rr;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
    end
    m_rr = 0;
  endtask

  task automatic model_step(input vec_t v, output logic ev, output logic [AW-1:0] ea);
    int fi, xi, victim, nfree;
    bit dm;
    fi = -1; xi = -1; dm = 0; nfree = 0; victim = -1;
    for (int i = 0; i < N; i++) begin
      if (m_v[i] && m_tag[i] == v.f && fi < 0) fi = i;
      if (m_v[i] && m_tag[i] == v.xp && xi < 0) xi = i;
      if (m_v[i] && m_tag[i] == v.dp) dm = 1;
      if (!m_v[i]) nfree++;
    end
    ev = (fi >= 0) && (m_ctr[fi] >= 2);
    ea = ev ? m_tgt[fi] : '0;
    if (v.db && !dm) begin
      if (nfree > 0) begin
        for (int i = N - 1; i >= 0; i--) if (!m_v[i]) victim = i;
      end else begin
        victim = m_rr;
      end
    end
    if (v.xv && xi >= 0 && xi != victim) begin
      if (v.xt) begin
        m_ctr[xi] = (m_ctr[xi] == 3) ? 3 : m_ctr[xi] + 1;
        m_tgt[xi] = v.xg;
      end else begin
        m_ctr[xi] = (m_ctr[xi] == 0) ? 0 : m_ctr[xi] - 1;
      end
    end
    if (victim >= 0) begin
      m_v[victim] = 1; m_tag[victim] = v.dp; m_tgt[victim] = v.dt; m_ctr[victim] = 1;
      if (nfree == 0) m_rr = (m_rr + 1) % N;
    end
  endtask

  initial begin
    logic          ev;
    logic [AW-1:0] ea;
    vec_t          v;
    logic [AW-1:0] rnd_pc;

    reset = 1'b1; f_pc = '0; d_is_branch = 0; d_pc = '0; d_target = '0;
    x_valid = 0; x_pc = '0; x_taken = 0; x_target = '0;
    #1;
    check("reset_valid", {31'b0, f_predict_valid}, 32'd0);
    check("reset_addr", f_predict_addr, 32'd0);
    @(posedge clk); #1;

    //             rst f       db dp      dt       xv xp      xt xg       ev ea
    vecs.push_back(mk(0, 'h100, 0, 0,     0,       0, 0,     0, 0,       0, 0));
    vecs.push_back(mk(0, 'h100, 0, 0,     0,       0, 0,     0, 0,       0, 0));
    vecs.push_back(mk(0, 'h100, 0, 0,     0,       0, 0,     0, 0,       0, 0));
    vecs.push_back(mk(0, 'h100, 1, 'h100, 'h200,   0, 0,     0, 0,       0, 0));
    vecs.push_back(mk(0, 'h100, 0, 0,     0,       0, 0,     0, 0,       0, 0));
    vecs.push_back(mk(0, 'h100, 0, 0,     0,       1, 'h100, 1, 'h200,   0, 0));
    vecs.push_back(mk(0, 'h100, 0, 0,     0,       0, 0,     0, 0,       1, 'h200));
    vecs.push_back(mk(0, 'h100, 0, 0,     0,       1, 'h100, 1, 'h200,   1, 'h200));
    vecs.push_back(mk(0, 'h100, 0, 0,     0,       1, 'h100, 1, 'h200,   1, 'h200));
    vecs.push_back(mk(0, 'h100, 0, 0,     0,       1, 'h100, 0, 0,       1, 'h200));
    vecs.push_back(mk(0, 'h100, 0, 0,     0,       0, 0,     0, 0,       1, 'h200));
    vecs.push_back(mk(0, 'h100, 0, 0,     0,       1, 'h100, 0, 0,       1, 'h200));
    vecs.push_back(mk(0, 'h100, 0, 0,     0,       1, 'h100, 0, 0,       0, 0));
    vecs.push_back(mk(0, 'h100, 0, 0,     0,       1, 'h100, 0, 0,       0, 0));
    vecs.push_back(mk(0, 'h100, 0, 0,     0,       1, 'h100, 1, 'h240,   0, 0));
    vecs.push_back(mk(0, 'h100, 0, 0,     0,       1, 'h100, 1, 'h240,   0, 0));
    vecs.push_back(mk(0, 'h100, 0, 0,     0,       0, 0,     0, 0,       1, 'h240));
    // replacement: fill 0x10..0x40, then 0x50/0x60 evict 0x10/0x20
    vecs.push_back(mk(1, 'h100, 0, 0,     0,       0, 0,     0, 0,       0, 0));
    vecs.push_back(mk(0, 'h10,  1, 'h10,  'h110,   0, 0,     0, 0,       0, 0));
    vecs.push_back(mk(0, 'h10,  1, 'h20,  'h120,   0, 0,     0, 0,       0, 0));
    vecs.push_back(mk(0, 'h10,  1, 'h30,  'h130,   0, 0,     0, 0,       0, 0));
    vecs.push_back(mk(0, 'h10,  1, 'h40,  'h140,   0, 0,     0, 0,       0, 0));
    vecs.push_back(mk(0, 'h10,  1, 'h50,  'h150,   1, 'h30,  1, 'h130,   0, 0));
    vecs.push_back(mk(0, 'h30,  1, 'h60,  'h160,   1, 'h10,  1, 'h999,   1, 'h130));
    vecs.push_back(mk(0, 'h10,  0, 0,     0,       1, 'h50,  1, 'h150,   0, 0));
    vecs.push_back(mk(0, 'h50,  0, 0,     0,       1, 'h10,  1, 'h999,   1, 'h150));
    vecs.push_back(mk(0, 'h10,  0, 0,     0,       0, 0,     0, 0,       0, 0));
    // same-cycle decode/exec on an existing PC: only training applies
    vecs.push_back(mk(0, 'h80,  1, 'h80,  'h280,   0, 0,     0, 0,       0, 0));
    vecs.push_back(mk(0, 'h80,  1, 'h80,  'h999,   1, 'h80,  1, 'h300,   0, 0));
    vecs.push_back(mk(0, 'h80,  0, 0,     0,       0, 0,     0, 0,       1, 'h300));
    vecs.push_back(mk(0, 'h40,  1, 'h90,  'h390,   0, 0,     0, 0,       0, 0));
    vecs.push_back(mk(0, 'h50,  0, 0,     0,       0, 0,     0, 0,       1, 'h150));
    // victim also the training target: allocation wins
    vecs.push_back(mk(0, 'h50,  1, 'hA0,  'h3A0,   1, 'h50,  1, 'h777,   1, 'h150));
    vecs.push_back(mk(0, 'h50,  0, 0,     0,       0, 0,     0, 0,       0, 0));
    vecs.push_back(mk(0, 'hA0,  0, 0,     0,       1, 'hA0,  1, 'h3A0,   0, 0));
    vecs.push_back(mk(0, 'hA0,  0, 0,     0,       0, 0,     0, 0,       1, 'h3A0));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      check($sformatf("vec%0d_valid", i), {31'b0, f_predict_valid}, {31'b0, vecs[i].ev});
      check($sformatf("vec%0d_addr", i), f_predict_addr, vecs[i].ea);
    end

    // asynchronous reset mid-stream while 0xA0 predicts taken
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, f_predict_valid}, 32'd0);
    check("async_rst_addr", f_predict_addr, 32'd0);
    @(posedge clk); #1;
    drive(mk(0, 'hA0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("post_rst_valid", {31'b0, f_predict_valid}, 32'd0);
    drive(mk(0, 'hA0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("post_rst_valid2", {31'b0, f_predict_valid}, 32'd0);

    // randomized traffic against the model (table is empty after the reset above)
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      v.rst = ($urandom_range(0, 299) == 0);
      v.f   = 32'(16 * $urandom_range(1, 8));
      v.db  = ($urandom_range(0, 9) < 4);
      v.dp  = 32'(16 * $urandom_range(1, 8));
      v.dt  = $urandom;
      v.xv  = ($urandom_range(0, 9) < 6);
      rnd_pc = 32'(16 * $urandom_range(1, 8));
      v.xp  = rnd_pc;
      v.xt  = ($urandom_range(0, 9) < 6);
      v.xg  = $urandom;
      if (v.rst) begin
        model_reset();
        ev = 0; ea = '0;
      end else begin
        model_step(v, ev, ea);
      end
      drive(v);
      check($sformatf("rnd%0d_valid", c), {31'b0, f_predict_valid}, {31'b0, ev});
      check($sformatf("rnd%0d_addr", c), f_predict_addr, ea);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
